// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame geometry.
package uart_pkg;

  localparam int BAUD_W     = 20;
  localparam int MIN_BAUD   = 15;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle-high level.
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/rx_baud_gen.sv
// UART receive timing: start-bit detection, frame window, mid-bit sample strobes
// and stop-bit framing check.
module rx_baud_gen #(
  parameter int BAUD_W     = uart_pkg::BAUD_W,
  parameter int MIN_BAUD   = uart_pkg::MIN_BAUD,
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx,
  output logic              rx_en,
  output logic              baud_clk,
  output logic              rx_bit,
  output logic              rx_done,
  output logic              frame_err
);

  import uart_pkg::*;

  localparam int K_W = $clog2(FRAME_BITS + 1);

  rx_state_t         state_reg;
  logic [BAUD_W-1:0] cnt_reg;
  logic [BAUD_W-1:0] baud_q_reg;
  logic [K_W-1:0]    k_reg;
  logic              rx_s;
  logic              rx_q_reg;
  logic              rx_en_reg;
  logic              baud_clk_reg;
  logic              rx_bit_reg;
  logic              rx_done_reg;
  logic              frame_err_reg;
  logic              fall;
  logic              baud_ok;
  logic              cnt_zero;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Edge-register stage: one extra cycle of history for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q_reg <= 1'b1;
    end else begin
      rx_q_reg <= rx_s;
    end
  end

  assign fall     = rx_q_reg & ~rx_s;
  assign baud_ok  = (baud >= BAUD_W'(MIN_BAUD));
  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      baud_q_reg    <= '0;
      k_reg         <= '0;
      rx_en_reg     <= 1'b0;
      baud_clk_reg  <= 1'b0;
      rx_bit_reg    <= 1'b1;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      baud_clk_reg <= 1'b0;
      rx_done_reg  <= 1'b0;
      if (!sel) begin
        // Standby abandons any frame in progress; the last sampled bit is kept.
        state_reg     <= IDLE;
        rx_en_reg     <= 1'b0;
        frame_err_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fall && baud_ok) begin
              cnt_reg    <= (baud >> 1) - BAUD_W'(1);
              baud_q_reg <= baud;
              k_reg      <= '0;
              rx_en_reg  <= 1'b1;
              state_reg  <= START;
            end
          end
          START: begin
            if (cnt_zero) begin
              if (rx_s) begin
                // Line back high at the half-bit point: a glitch, not a start bit.
                rx_en_reg <= 1'b0;
                state_reg <= IDLE;
              end else begin
                baud_clk_reg <= 1'b1;
                rx_bit_reg   <= 1'b0;
                k_reg        <= K_W'(1);
                cnt_reg      <= baud_q_reg - BAUD_W'(1);
                state_reg    <= RUN;
              end
            end else begin
              cnt_reg <= cnt_reg - BAUD_W'(1);
            end
          end
          RUN: begin
            if (cnt_zero) begin
              baud_clk_reg <= 1'b1;
              rx_bit_reg   <= rx_s;
              k_reg        <= k_reg + K_W'(1);
              cnt_reg      <= baud_q_reg - BAUD_W'(1);
              if (k_reg == K_W'(FRAME_BITS - 1)) begin
                frame_err_reg <= ~rx_s;
                rx_en_reg     <= 1'b0;
                rx_done_reg   <= 1'b1;
                state_reg     <= DONE;
              end
            end else begin
              cnt_reg <= cnt_reg - BAUD_W'(1);
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_en     = rx_en_reg;
  assign baud_clk  = baud_clk_reg;
  assign rx_bit    = rx_bit_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;

endmodule
